// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - default sizes, counter-width helper and data type for sync_fifo
package sync_fifo_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  // The count has to represent DEPTH itself, so it needs one bit more than the pointers.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W = cnt_w(DEPTH);

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - DEPTH x DATA_W register array, one write port, one registered read port
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage is deliberately left out of reset; only the output register clears.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with count and flags; SYNC_FIFO_ERR_EN adds sticky overflow/underflow
module sync_fifo #(
  parameter int DATA_W = sync_fifo_pkg::DATA_W,
  parameter int DEPTH  = sync_fifo_pkg::DEPTH,
  parameter int CNT_W  = sync_fifo_pkg::cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
`ifdef SYNC_FIFO_ERR_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [CNT_W-1:0]  fifo_cnt
);

  import sync_fifo_pkg::*;

  localparam int AW = CNT_W - 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

  // Gating with the flags makes full-write and empty-read no-ops.
  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fifo_cnt = cnt_q;

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky: once a bad request is seen the flag stays up until reset.
  always_comb begin
    overflow_d  = overflow_q | (wr & full);
    underflow_d = underflow_q | (rd & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          wr;
  logic          rd;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;
  logic [CW-1:0] fifo_cnt;
`ifdef SYNC_FIFO_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  sync_fifo #(.DATA_W(DW), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
`ifdef SYNC_FIFO_ERR_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_dout;
  logic          exp_ovf;
  logic          exp_unf;
  int            errors;
  int            checks;

  // Updates the scoreboard from its own state before the edge, then clocks the DUT.
  task automatic drive(input logic w, input logic r, input logic [DW-1:0] d);
    bit do_wr;
    bit do_rd;
    wr      = w;
    rd      = r;
    data_in = d;
    do_wr   = w && (sb.size() < DP);
    do_rd   = r && (sb.size() > 0);
    if (w && sb.size() == DP) exp_ovf = 1'b1;
    if (r && sb.size() == 0)  exp_unf = 1'b1;
    if (do_rd) exp_dout = sb.pop_front();
    if (do_wr) sb.push_back(d);
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr  = 1'b1;
    rd  = 1'b1;
    data_in = 8'hAA;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr  = 1'b0;
    rd  = 1'b0;
    sb.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", fifo_cnt); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (data_out !== 8'd0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", data_out); end
`ifdef SYNC_FIFO_ERR_EN
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {overflow, underflow}); end
`endif
  endtask

  task automatic test_write_concurrent();
    drive(1'b1, 1'b0, 8'd1);
    checks++; if (fifo_cnt !== 4'd1) begin errors++; $display("FAIL push1_cnt: got %0d expected 1", fifo_cnt); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL push1_empty: got %b expected 0", empty); end
    drive(1'b1, 1'b1, 8'd2);
    checks++; if (data_out !== exp_dout || data_out !== 8'd1) begin errors++; $display("FAIL rw_dout: got %0d expected 1", data_out); end
    checks++; if (fifo_cnt !== 4'd1) begin errors++; $display("FAIL rw_cnt: got %0d expected 1", fifo_cnt); end
  endtask

  task automatic test_fill_full();
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, 1'b0, 8'(i * 10));
      checks++; if (fifo_cnt !== CW'(sb.size())) begin errors++; $display("FAIL fill_cnt[%0d]: got %0d expected %0d", i, fifo_cnt, sb.size()); end
    end
    checks++; if (fifo_cnt !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL full_flag: got cnt=%0d full=%b expected cnt=8 full=1", fifo_cnt, full); end
    drive(1'b1, 1'b0, 8'd80);
    checks++; if (fifo_cnt !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL full_drop: got cnt=%0d full=%b expected cnt=8 full=1", fifo_cnt, full); end
`ifdef SYNC_FIFO_ERR_EN
    checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL overflow_set: got %b expected %b", overflow, exp_ovf); end
`endif
  endtask

  task automatic test_drain();
    logic [DW-1:0] want [8];
    want = '{8'd2, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70};
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      checks++; if (data_out !== exp_dout || data_out !== want[i]) begin errors++; $display("FAIL drain[%0d]: got %0d expected %0d", i, data_out, want[i]); end
    end
    checks++; if (fifo_cnt !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got cnt=%0d empty=%b expected cnt=0 empty=1", fifo_cnt, empty); end
    drive(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'd70) begin errors++; $display("FAIL empty_pop_hold: got %0d expected 70", data_out); end
`ifdef SYNC_FIFO_ERR_EN
    checks++; if (underflow !== exp_unf) begin errors++; $display("FAIL underflow_set: got %b expected %b", underflow, exp_unf); end
`endif
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 8'd140);
    drive(1'b1, 1'b0, 8'd5);
    drive(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'd140) begin errors++; $display("FAIL wrap_pop0: got %0d expected 140", data_out); end
    drive(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'd5 || empty !== 1'b1) begin errors++; $display("FAIL wrap_pop1: got %0d empty=%b expected 5 empty=1", data_out, empty); end
  endtask

  task automatic test_full_simul_reset();
    for (int i = 0; i < DP; i++) drive(1'b1, 1'b0, 8'(100 + i * 3));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL refill_full: got %b expected 1", full); end
    drive(1'b1, 1'b1, 8'hEE);
    checks++; if (data_out !== exp_dout || data_out !== 8'd100) begin errors++; $display("FAIL full_rw_dout: got %0d expected 100", data_out); end
    checks++; if (fifo_cnt !== 4'd7 || full !== 1'b0) begin errors++; $display("FAIL full_rw_cnt: got cnt=%0d full=%b expected cnt=7 full=0", fifo_cnt, full); end
`ifdef SYNC_FIFO_ERR_EN
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_rw_ovf: got %b expected 1", overflow); end
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      checks++; if (data_out !== exp_dout) begin errors++; $display("FAIL partial_pop[%0d]: got %0d expected %0d", i, data_out, exp_dout); end
    end
    checks++; if (fifo_cnt !== 4'd3) begin errors++; $display("FAIL pre_reset_cnt: got %0d expected 3", fifo_cnt); end
    do_reset();
    checks++; if (fifo_cnt !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL mid_reset: got cnt=%0d empty=%b full=%b expected 0/1/0", fifo_cnt, empty, full); end
    checks++; if (data_out !== 8'd0) begin errors++; $display("FAIL mid_reset_dout: got %0d expected 0", data_out); end
`ifdef SYNC_FIFO_ERR_EN
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL mid_reset_err: got %b expected 00", {overflow, underflow}); end
`endif
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h55 || empty !== 1'b1) begin errors++; $display("FAIL post_reset_fresh: got %0d empty=%b expected 85 empty=1", data_out, empty); end
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b0;
    wr       = 1'b0;
    rd       = 1'b0;
    data_in  = '0;
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    errors   = 0;
    checks   = 0;
    #2;
    test_reset();
    test_write_concurrent();
    test_fill_full();
    test_drain();
    test_wrap();
    test_full_simul_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
